// File: rtl/sha256_padder_if.sv
// Word-stream and SHA-256 core control bundle shared by the padder and its environment.
interface sha256_padder_if;
    logic [31:0]  s_data;
    logic         s_valid;
    logic         s_last;
    logic [1:0]   s_last_bytes;
    logic         s_ready;
    logic         core_ready;
    logic         core_init;
    logic         core_next;
    logic [511:0] core_block;
    logic         busy;
    logic         msg_done;

    modport master (
        output s_data, s_valid, s_last, s_last_bytes, core_ready,
        input  s_ready, core_init, core_next, core_block, busy, msg_done
    );

    modport slave (
        input  s_data, s_valid, s_last, s_last_bytes, core_ready,
        output s_ready, core_init, core_next, core_block, busy, msg_done
    );
endinterface

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs a big-endian word stream into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit length, and sequences init/next into the core.
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    sha256_padder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [511:0]     blk_q, blk_d;
    logic [3:0]       w_idx_q, w_idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             final_q, final_d;
    logic             extra_q, extra_d;
    logic             extra80_q, extra80_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic             s_ready_q, s_ready_d;
    logic             core_init_q, core_init_d;
    logic             core_next_q, core_next_d;
    logic             msg_done_q, msg_done_d;
    logic             busy_q, busy_d;

    logic             xfer_s;
    logic             complete_s;
    logic             fire_s;
    logic [2:0]       kbytes_s;
    logic [31:0]      word_s;
    logic [5:0]       len_inc_s;
    logic [LEN_W-1:0] len_new_s;
    logic [4:0]       pad_idx_s;

    // Keeps the k valid MSB-aligned bytes of a final word and appends 0x80 when it fits.
    function automatic logic [31:0] last_word(input logic [31:0] data, input logic [1:0] nbytes);
        logic [31:0] w;
        case (nbytes)
            2'd1:    w = {data[31:24], 8'h80, 16'h0000};
            2'd2:    w = {data[31:16], 8'h80, 8'h00};
            2'd3:    w = {data[31:8], 8'h80};
            default: w = data;
        endcase
        return w;
    endfunction

    // Decode of the incoming beat: stored word, length increment, 0x80 word position.
    always_comb begin
        xfer_s   = bus.s_valid & s_ready_q;
        kbytes_s = (bus.s_last_bytes == 2'd0) ? 3'd4 : {1'b0, bus.s_last_bytes};
        if (bus.s_last) begin
            word_s    = last_word(bus.s_data, bus.s_last_bytes);
            len_inc_s = {kbytes_s, 3'b000};
        end else begin
            word_s    = bus.s_data;
            len_inc_s = 6'd32;
        end
        len_new_s = len_q + LEN_W'(len_inc_s);
        pad_idx_s = {1'b0, w_idx_q} + ((kbytes_s == 3'd4) ? 5'd1 : 5'd0);
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        w_idx_d     = w_idx_q;
        len_d       = len_q;
        first_d     = first_q;
        final_d     = final_q;
        extra_d     = extra_q;
        extra80_d   = extra80_q;
        wait_cnt_d  = wait_cnt_q;
        busy_d      = busy_q;
        core_init_d = 1'b0;
        core_next_d = 1'b0;
        msg_done_d  = 1'b0;
        complete_s  = 1'b0;
        fire_s      = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (xfer_s) begin
                    busy_d  = 1'b1;
                    len_d   = len_new_s;
                    w_idx_d = w_idx_q + 4'd1;
                    if (bus.s_last) begin
                        for (int i = 0; i < 16; i++) begin
                            if (i > int'(w_idx_q)) begin
                                blk_d[511 - 32*i -: 32] = 32'h0000_0000;
                            end else begin
                                blk_d[511 - 32*i -: 32] = blk_q[511 - 32*i -: 32];
                            end
                        end
                        blk_d[511 - 32*int'(w_idx_q) -: 32] = word_s;
                        // A full last word pushes 0x80 into the next word, if this block has one.
                        if ((kbytes_s == 3'd4) && (w_idx_q != 4'd15)) begin
                            blk_d[511 - 32*(int'(w_idx_q) + 1) -: 32] = 32'h8000_0000;
                        end else begin
                            blk_d[511 - 32*int'(w_idx_q) -: 32] = word_s;
                        end
                        if (pad_idx_s <= 5'd13) begin
                            blk_d[63:0] = 64'(len_new_s);
                            final_d     = 1'b1;
                            extra_d     = 1'b0;
                            extra80_d   = 1'b0;
                        end else begin
                            final_d     = 1'b0;
                            extra_d     = 1'b1;
                            extra80_d   = (pad_idx_s == 5'd16);
                        end
                        w_idx_d    = 4'd0;
                        complete_s = 1'b1;
                    end else begin
                        blk_d[511 - 32*int'(w_idx_q) -: 32] = word_s;
                        final_d    = 1'b0;
                        extra_d    = 1'b0;
                        extra80_d  = 1'b0;
                        complete_s = (w_idx_q == 4'd15);
                    end
                end else begin
                    busy_d = busy_q;
                end
                if (complete_s) begin
                    if (bus.core_ready) begin
                        fire_s = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_ISSUE: begin
                fire_s = bus.core_ready;
            end
            ST_WAIT: begin
                // The core still shows ready for a cycle after sampling the pulse.
                if (wait_cnt_q != 2'd0) begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end else if (bus.core_ready) begin
                    if (final_q) begin
                        msg_done_d = 1'b1;
                        busy_d     = 1'b0;
                        len_d      = '0;
                        first_d    = 1'b1;
                        final_d    = 1'b0;
                        state_d    = ST_FILL;
                    end else if (extra_q) begin
                        blk_d     = {(extra80_q ? 32'h8000_0000 : 32'h0000_0000), 416'h0, 64'(len_q)};
                        extra_d   = 1'b0;
                        extra80_d = 1'b0;
                        final_d   = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        if (fire_s) begin
            core_init_d = first_q;
            core_next_d = ~first_q;
            first_d     = 1'b0;
            wait_cnt_d  = 2'd2;
            state_d     = ST_WAIT;
        end else begin
            core_init_d = 1'b0;
            core_next_d = 1'b0;
        end

        s_ready_d = (state_d == ST_FILL);
    end

    // State and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            blk_q       <= 512'h0;
            w_idx_q     <= 4'd0;
            len_q       <= '0;
            first_q     <= 1'b1;
            final_q     <= 1'b0;
            extra_q     <= 1'b0;
            extra80_q   <= 1'b0;
            wait_cnt_q  <= 2'd0;
            s_ready_q   <= 1'b1;
            core_init_q <= 1'b0;
            core_next_q <= 1'b0;
            msg_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            w_idx_q     <= w_idx_d;
            len_q       <= len_d;
            first_q     <= first_d;
            final_q     <= final_d;
            extra_q     <= extra_d;
            extra80_q   <= extra80_d;
            wait_cnt_q  <= wait_cnt_d;
            s_ready_q   <= s_ready_d;
            core_init_q <= core_init_d;
            core_next_q <= core_next_d;
            msg_done_q  <= msg_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.core_init  = core_init_q;
    assign bus.core_next  = core_next_q;
    assign bus.core_block = blk_q;
    assign bus.busy       = busy_q;
    assign bus.msg_done   = msg_done_q;

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream message-formatting stage for the SHA-256 core.
- Accepts an arbitrary-length byte message as a big-endian 32-bit word stream with valid/ready handshake.
- Assembles 512-bit blocks and applies FIPS 180-4 padding: 0x80 byte, zero fill, 64-bit big-endian bit length.
- Drives the core's init/next/block inputs and sequences against its ready flag; pulses msg_done when the final digest is available.

Parameters:
- LEN_W, 64, width of the message bit-length counter. Fixed at 64 for FIPS compliance; length wraps mod 2^64.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- s_data  in  32  message word; byte 0 = s_data[31:24]
- s_valid  in  1  s_data valid
- s_last  in  1  this word ends the message
- s_last_bytes  in  2  valid bytes in the last word: 0 = 4, 1..3 = that many MSB-aligned bytes; ignored unless s_last
- s_ready  out  1  padder accepts a word this cycle
- core_ready  in  1  core ready flag
- core_init  out  1  one-cycle pulse: process core_block as first block
- core_next  out  1  one-cycle pulse: process core_block as a continuation block
- core_block  out  512  block to core; word 0 = [511:480]
- busy  out  1  message in progress (first word accepted through msg_done)
- msg_done  out  1  one-cycle pulse: core finished the final block, digest valid

Behaviour:
- Reset, asynchronous: state=FILL, s_ready=1, core_init=core_next=msg_done=busy=0, core_block=0, word index=0, bit length=0, first-block flag=1.
- FILL:
  - s_ready=1. A transfer occurs on s_valid&&s_ready. Word stored at index w_idx, w_idx increments, length += 32.
  - w_idx reaching 16 with !s_last -> ISSUE.
  - On s_last with k valid bytes (k=4 when s_last_bytes=0): store the k bytes, zero the lower bytes, length += 8*k.
  - Place 0x80 in the byte immediately after the last data byte. When k=4 it goes in byte 0 of the next word; if that word would be index 16, it goes in the following block.
  - Fill all remaining words with zeros.
  - If the 0x80 lands in words 0..13: words 14..15 = length[63:0]; the block is final.
  - Otherwise words 14..15 stay zero; an extra block follows holding zeros (plus 0x80 in word 0 if not yet placed) and the length in words 14..15.
- ISSUE:
  - s_ready=0. Wait for core_ready=1, then pulse core_init (first block) or core_next for exactly one cycle. Clear the first-block flag.
  - core_block holds stable from the pulse until the core returns ready.
- WAIT:
  - Ignore core_ready in the first cycle after the pulse; the core drops ready one cycle after sampling init/next. From the second cycle on, wait for core_ready=1.
  - If more data is pending: -> FILL with w_idx=0.
  - If the extra pad block is pending: -> ISSUE with that block.
  - If the final block is done: pulse msg_done, clear busy, reset length and first-block flag, -> FILL.
- Latency: last input word to core pulse = 1 cycle when core_ready=1. Final core ready to msg_done = 1 cycle.
- Throughput: s_ready=0 from block completion until the core returns ready; there is no double buffering.
- core_init and core_next are never asserted together, and never asserted while core_ready=0.
- Empty messages are unsupported; every message carries at least one byte.
- Reset mid-message aborts immediately with no core pulse. The core is reset on the same reset_n.

Test Plan:
- "abc": one word 0x61626300, s_last, s_last_bytes=3 -> one core_init with core_block=0x61626380 followed by 0x00... and final word 0x00000018; no core_next; msg_done after ready; core digest BA7816BF...F20015AD.
- 56-byte message "abcdbcdecdef...nopq" (14 words, last full) -> core_init block = data words then 0x80000000, 0x00000000; core_next block = zeros with final word 0x000001C0; final digest 248D6A61...19DB06C1.
- 55-byte message (last word 3 bytes) -> single block: 0x80 at byte 55, words 14..15 = 0x00000000_000001B8; exactly one core_init.
- 64-byte message (16 full words) -> core_init with raw data, then core_next block 0x80000000, zeros, length 0x00000200; msg_done once.
- Backpressure: s_valid held high while the core is busy -> s_ready=0 from block completion until core_ready returns; no word lost or duplicated; 9-block 4328-bit message (length 0x10E8) gives digest 7758a30b...81fbcf9d.
- Reset mid-fill (after 5 words) then "abc" -> no spurious core pulse; the following "abc" hashes correctly with core_init (not core_next).
